// File: rtl/if_fetch.sv
// Byte-serial instruction fetch: 4 byte reads assembled little-endian, result held until accepted.
// Optional misaligned-branch exception path under `IF_MISALIGN_EXC_EN; otherwise targets are aligned down.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_done,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
`ifdef IF_MISALIGN_EXC_EN
  ,
  output logic        if_exc_misalign
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1
`ifdef IF_MISALIGN_EXC_EN
    ,
    EXC   = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] byte_buf_q, byte_buf_d;
  logic [31:0] if_pc_d, if_inst_d;
  logic        if_valid_d;
`ifdef IF_MISALIGN_EXC_EN
  logic        exc_d;
`endif

  assign mem_req  = (state_q == FETCH);
  assign mem_addr = pc_q + {30'd0, cnt_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      cnt_q      <= 2'd0;
      byte_buf_q <= 24'd0;
      if_pc      <= 32'd0;
      if_inst    <= 32'd0;
      if_valid   <= 1'b0;
`ifdef IF_MISALIGN_EXC_EN
      if_exc_misalign <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      byte_buf_q <= byte_buf_d;
      if_pc      <= if_pc_d;
      if_inst    <= if_inst_d;
      if_valid   <= if_valid_d;
`ifdef IF_MISALIGN_EXC_EN
      if_exc_misalign <= exc_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    byte_buf_d = byte_buf_q;
    if_pc_d    = if_pc;
    if_inst_d  = if_inst;
    if_valid_d = if_valid;
`ifdef IF_MISALIGN_EXC_EN
    exc_d      = if_exc_misalign;
`endif

    if (branch_flag) begin
      // Redirect wins over any byte arriving this cycle; partial word is dropped.
      cnt_d      = 2'd0;
      if_valid_d = 1'b0;
      state_d    = FETCH;
`ifdef IF_MISALIGN_EXC_EN
      pc_d  = branch_target;
      exc_d = 1'b0;
      if (branch_target[1:0] != 2'b00) begin
        state_d    = EXC;
        if_valid_d = 1'b1;
        if_pc_d    = branch_target;
        if_inst_d  = 32'h00000013;
        exc_d      = 1'b1;
      end
`else
      pc_d = {branch_target[31:2], 2'b00};
`endif
    end else begin
      if (if_valid && !stall) begin
        if_valid_d = 1'b0;
`ifdef IF_MISALIGN_EXC_EN
        exc_d      = 1'b0;
`endif
      end
      case (state_q)
        FETCH: begin
          if (mem_done) begin
            if (cnt_q == 2'd3) begin
              if_inst_d  = {mem_rdata, byte_buf_q};
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
              pc_d       = pc_q + 32'd4;
              cnt_d      = 2'd0;
              state_d    = WAIT;
            end else begin
              byte_buf_d[8*cnt_q +: 8] = mem_rdata;
              cnt_d                    = cnt_q + 2'd1;
            end
          end
        end
        WAIT: begin
          if (!if_valid || !stall) state_d = FETCH;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, assembly, stall hold, gapped memory, branch flush, PC wrap, misaligned target.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_done;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
`ifdef IF_MISALIGN_EXC_EN
  logic        if_exc_misalign;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  if_fetch #(.RESET_PC(32'h00000100)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
`ifdef IF_MISALIGN_EXC_EN
    , .if_exc_misalign(if_exc_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Requests must be issued at the expected address before the byte is delivered.
  task automatic give_byte(input logic [31:0] addr, input logic [7:0] data);
    check("byte_req", {31'd0, mem_req}, 32'd1);
    check("byte_addr", mem_addr, addr);
    mem_done  = 1'b1;
    mem_rdata = data;
    tick();
    mem_done  = 1'b0;
    mem_rdata = 8'h00;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
    check({tag, "_pc"}, if_pc, pc);
    check({tag, "_inst"}, if_inst, inst);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'd0;
    mem_done = 1'b0; mem_rdata = 8'h00;
    tick(); tick();

    check_out("reset", 1'b0, 32'h0, 32'h0);
    check("reset_req", {31'd0, mem_req}, 32'd1);
    check("reset_addr", mem_addr, 32'h00000100);
`ifdef IF_MISALIGN_EXC_EN
    check("reset_exc", {31'd0, if_exc_misalign}, 32'd0);
`endif
    rst = 1'b1;

    // Back-to-back bytes: word visible four cycles after FETCH entry.
    give_byte(32'h100, 8'h13);
    give_byte(32'h101, 8'h05);
    give_byte(32'h102, 8'h10);
    check("pre4_valid", {31'd0, if_valid}, 32'd0);
    stall = 1'b1;
    give_byte(32'h103, 8'h00);
    check_out("first", 1'b1, 32'h100, 32'h00100513);
    check("first_wait_req", {31'd0, mem_req}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall_hold", 1'b1, 32'h100, 32'h00100513);
      check("stall_req", {31'd0, mem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check("consume_valid", {31'd0, if_valid}, 32'd0);
    check("consume_req", {31'd0, mem_req}, 32'd1);
    check("consume_addr", mem_addr, 32'h104);

    // Slow memory: two idle cycles before each byte.
    for (int b = 0; b < 4; b++) begin
      tick(); tick();
      check("gap_addr", mem_addr, 32'h104 + b);
      check("gap_valid", {31'd0, if_valid}, 32'd0);
      case (b)
        0: give_byte(32'h104, 8'hef);
        1: give_byte(32'h105, 8'hbe);
        2: give_byte(32'h106, 8'had);
        default: give_byte(32'h107, 8'hde);
      endcase
    end
    check_out("gapped", 1'b1, 32'h104, 32'hdeadbeef);
    tick();
    check("gapped_consume_valid", {31'd0, if_valid}, 32'd0);
    check("gapped_next_addr", mem_addr, 32'h108);

    // Branch arriving together with the third byte discards it.
    give_byte(32'h108, 8'h11);
    give_byte(32'h109, 8'h22);
    mem_done = 1'b1; mem_rdata = 8'haa;
    branch_flag = 1'b1; branch_target = 32'h200;
    tick();
    mem_done = 1'b0; branch_flag = 1'b0;
    check("br_mid_valid", {31'd0, if_valid}, 32'd0);
    check("br_mid_req", {31'd0, mem_req}, 32'd1);
    check("br_mid_addr", mem_addr, 32'h200);
    give_byte(32'h200, 8'h93);
    give_byte(32'h201, 8'h00);
    give_byte(32'h202, 8'h10);
    stall = 1'b1;
    give_byte(32'h203, 8'h00);
    check_out("after_br", 1'b1, 32'h200, 32'h00100093);

    // Branch while a stalled word is presented flushes it.
    branch_flag = 1'b1; branch_target = 32'h200;
    tick();
    branch_flag = 1'b0;
    check("br_stall_valid", {31'd0, if_valid}, 32'd0);
    check("br_stall_addr", mem_addr, 32'h200);
    check("br_stall_req", {31'd0, mem_req}, 32'd1);

    // Fetch at the top of the address space wraps PC to zero.
    stall = 1'b0;
    branch_flag = 1'b1; branch_target = 32'hfffffffc;
    tick();
    branch_flag = 1'b0;
    give_byte(32'hfffffffc, 8'h01);
    give_byte(32'hfffffffd, 8'h02);
    give_byte(32'hfffffffe, 8'h03);
    give_byte(32'hffffffff, 8'h04);
    check_out("wrap", 1'b1, 32'hfffffffc, 32'h04030201);
    tick();
    check("wrap_valid", {31'd0, if_valid}, 32'd0);
    check("wrap_addr", mem_addr, 32'h00000000);

    // Misaligned target.
    branch_flag = 1'b1; branch_target = 32'h202;
    tick();
    branch_flag = 1'b0;
`ifdef IF_MISALIGN_EXC_EN
    check_out("exc", 1'b1, 32'h202, 32'h00000013);
    check("exc_flag", {31'd0, if_exc_misalign}, 32'd1);
    check("exc_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("exc_consumed_valid", {31'd0, if_valid}, 32'd0);
    check("exc_consumed_flag", {31'd0, if_exc_misalign}, 32'd0);
    tick();
    check("exc_idle_req", {31'd0, mem_req}, 32'd0);
    branch_flag = 1'b1; branch_target = 32'h200;
    tick();
    branch_flag = 1'b0;
`else
    check("misalign_valid", {31'd0, if_valid}, 32'd0);
    check("misalign_req", {31'd0, mem_req}, 32'd1);
    check("misalign_addr", mem_addr, 32'h200);
`endif

    // Reset in the middle of a word restarts at RESET_PC.
    give_byte(32'h200, 8'h55);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_out("rst_mid", 1'b0, 32'h0, 32'h0);
    check("rst_mid_addr", mem_addr, 32'h100);
    check("rst_mid_req", {31'd0, mem_req}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage feeding the `if_id` pipeline register. It owns the program counter and fetches each 32-bit instruction as four bytes over the byte-wide memory port, then assembles them little-endian. It presents `if_pc`/`if_inst` with a valid flag that holds until the consumer accepts. It redirects on branch requests from EX and flushes any partially fetched instruction.

## Interface
- `RESET_PC`, default `32'h00000000`: PC loaded at reset.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-low reset; `rst==0` at a posedge resets the block.
- `stall` in 1: consumer cannot accept this cycle.
- `branch_flag` in 1: one-cycle redirect request.
- `branch_target` in 32: redirect PC, valid when `branch_flag=1`.
- `mem_req` out 1: byte read request.
- `mem_addr` out 32: byte address of the current request.
- `mem_rdata` in 8: read byte, valid when `mem_done=1`.
- `mem_done` in 1: `mem_rdata` holds the byte at `mem_addr` this cycle.
- `if_pc` out 32: PC of the presented instruction.
- `if_inst` out 32: presented instruction.
- `if_valid` out 1: `if_pc`/`if_inst` are valid.
- `if_exc_misalign` out 1: only present with `IF_MISALIGN_EXC_EN`.

## Operation
- **Registers**
  - `pc` (32 bits), `cnt` (2 bits, byte index), `buf` (24 bits, bytes 0..2).
  - `state` ∈ {FETCH, WAIT, EXC (macro only)}.
  - Output regs: `if_pc`, `if_inst`, `if_valid`.
- **Reset:** `pc=RESET_PC`, `cnt=0`, `state=FETCH`, `if_pc=0`, `if_inst=0`, `if_valid=0`, `if_exc_misalign=0`.
- **Memory outputs:** combinational from registers only.
  - `mem_req = (state==FETCH)`.
  - `mem_addr = pc + cnt` (mod 2^32).
- **FETCH, byte capture:** on `mem_done`, for `cnt<3`: `buf[8*cnt+:8] <= mem_rdata`, `cnt++`.
- **FETCH, completion:** on `mem_done` with `cnt==3`:
  - `if_inst <= {mem_rdata, buf}`, `if_pc <= pc`, `if_valid <= 1`.
  - `pc <= pc + 4` (wraps; `0xFFFFFFFC` → `0`), `cnt <= 0`, `state <= WAIT`.
- **Consume:** an instruction is consumed in any cycle with `if_valid=1 && stall=0`; `if_valid` clears at that edge.
- **WAIT:** if `if_valid==0` or `stall==0`, go to FETCH, clearing `if_valid` if it was consumed. Otherwise hold all outputs.
  - This guarantees the output slot is empty whenever FETCH completes.
- **Branch:** `branch_flag=1` has priority over everything except reset.
  - `pc <= branch_target`, `cnt <= 0`, `if_valid <= 0`, `state <= FETCH`.
  - Any `mem_done` in the same cycle is ignored; the partial `buf` is discarded.
  - Applies regardless of `stall` or state.
- **Memory contract:** `mem_done` is only honoured while `mem_req=1`. Memory may take any number of cycles per byte. `mem_addr` is stable from request until `mem_done` or a branch.
- **Reset mid-fetch:** the partial instruction is discarded; the next request is `RESET_PC`.

## Timing
- The FETCH request is visible in the same cycle state enters FETCH.
- With `mem_done` every cycle from cycle T (entry): bytes arrive at T..T+3 and `if_valid=1` from T+4.
- With `stall=0` at T+4: consumed, FETCH re-entered at T+5. Steady-state throughput is 1 instruction per 5 cycles.
- Stall holds `if_pc`/`if_inst`/`if_valid` unchanged and issues no `mem_req`.
- Branch at cycle B: `if_valid=0` and `mem_addr=branch_target` at B+1.

## Configuration
- `IF_MISALIGN_EXC_EN` defined:
  - A branch with `branch_target[1:0]!=0` goes to EXC instead of FETCH.
  - Sets `if_valid=1`, `if_pc=branch_target`, `if_inst=32'h00000013` (NOP), `if_exc_misalign=1`, with `mem_req=0`.
  - After it is consumed: `if_valid=0`, `if_exc_misalign=0`, the block stays idle in EXC until the next branch.
- Not defined:
  - The port is absent and the target is aligned down (`pc <= {branch_target[31:2],2'b00}`).
  - No exception path exists.

## Test plan
- Reset with `RESET_PC=0x100`, memory returns bytes 13,05,10,00 at 0x100..0x103 -> `mem_addr` sequence 0x100..0x103, then `if_pc=0x100`, `if_inst=0x00100513`, `if_valid=1` at T+4.
- `stall=1` for 3 cycles after the first instruction -> outputs held, `mem_req=0`; release -> next fetch starts at `mem_addr=0x104`.
- `mem_done` with 2-cycle gaps between bytes -> same assembled word; `if_valid` rises only after the 4th byte.
- `branch_flag` with target 0x200 while `cnt==2` and `mem_done=1` -> byte dropped, `if_valid=0`, next `mem_addr=0x200`; also the same branch while `if_valid=1` and `stall=1` -> flushed.
- PC=0xFFFFFFFC fetch completes -> next `mem_addr=0x00000000`.
- Target 0x202: with `IF_MISALIGN_EXC_EN` -> `if_exc_misalign=1`, `if_pc=0x202`, `if_inst=0x13`, no `mem_req`; without it -> fetch from 0x200.
